// File: rtl/decode_step.sv
// RV32I decode stage: decodes one fetched instruction per handshake into a
// one-entry output register that feeds execute; an illegal word halts the stage.
module decode_step #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            enable_step_i,
   input  logic            fetch_valid_i,
   input  logic [XLEN-1:0] instruction_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            decode_ready_o,
   input  logic            flush_i,
   input  logic            execute_ready_i,
   output logic            decode_valid_o,
   output logic [XLEN-1:0] pc_o,
   output logic [4:0]      rs1_o,
   output logic [4:0]      rs2_o,
   output logic [4:0]      rd_o,
   output logic [XLEN-1:0] imm_o,
   output logic [2:0]      funct3_o,
   output logic            funct7b5_o,
   output logic [3:0]      op_class_o,
   output logic            reg_write_o,
   output logic            illegal_o
);

   localparam logic [3:0] C_LUI    = 4'd0;
   localparam logic [3:0] C_AUIPC  = 4'd1;
   localparam logic [3:0] C_JAL    = 4'd2;
   localparam logic [3:0] C_JALR   = 4'd3;
   localparam logic [3:0] C_BRANCH = 4'd4;
   localparam logic [3:0] C_LOAD   = 4'd5;
   localparam logic [3:0] C_STORE  = 4'd6;
   localparam logic [3:0] C_OP_IMM = 4'd7;
   localparam logic [3:0] C_OP     = 4'd8;
   localparam logic [3:0] C_FENCE  = 4'd9;
   localparam logic [3:0] C_SYSTEM = 4'd10;
   localparam logic [3:0] C_ILL    = 4'd15;

   typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_HALT} state_t;

   state_t r_state;
   state_t w_state_next;

   logic [31:0]     w_ins;
   logic [6:0]      w_opcode;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic [3:0]      w_class;
   logic            w_illegal;
   logic            w_writes;
   logic            w_rd_keep;
   logic [31:0]     w_imm32;
   logic [4:0]      w_rd;
   logic            w_reg_write;
   logic [XLEN-1:0] w_imm;
   logic            w_accept;

   assign w_ins    = instruction_i[31:0];
   assign w_opcode = w_ins[6:0];
   assign w_f3     = w_ins[14:12];
   assign w_f7     = w_ins[31:25];

   always_comb begin
      w_class   = C_ILL;
      w_illegal = 1'b1;
      w_writes  = 1'b0;
      w_rd_keep = 1'b0;
      w_imm32   = 32'd0;
      case (w_opcode)
         7'b0110111: begin
            w_class = C_LUI;    w_illegal = 1'b0; w_writes = 1'b1; w_rd_keep = 1'b1;
            w_imm32 = {w_ins[31:12], 12'd0};
         end
         7'b0010111: begin
            w_class = C_AUIPC;  w_illegal = 1'b0; w_writes = 1'b1; w_rd_keep = 1'b1;
            w_imm32 = {w_ins[31:12], 12'd0};
         end
         7'b1101111: begin
            w_class = C_JAL;    w_illegal = 1'b0; w_writes = 1'b1; w_rd_keep = 1'b1;
            w_imm32 = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
         end
         7'b1100111: begin
            w_class = C_JALR;   w_illegal = (w_f3 != 3'd0); w_writes = 1'b1; w_rd_keep = 1'b1;
            w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
         end
         7'b1100011: begin
            w_class = C_BRANCH; w_illegal = (w_f3 == 3'd2) || (w_f3 == 3'd3);
            w_imm32 = {{19{w_ins[31]}}, w_ins[31], w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
         end
         7'b0000011: begin
            w_class = C_LOAD;   w_illegal = (w_f3 == 3'd3) || (w_f3 >= 3'd6);
            w_writes = 1'b1; w_rd_keep = 1'b1;
            w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
         end
         7'b0100011: begin
            w_class = C_STORE;  w_illegal = (w_f3 > 3'd2);
            w_imm32 = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
         end
         7'b0010011: begin
            // Shift-immediates reuse funct7 bits; all other funct3 values are free-form.
            w_class = C_OP_IMM; w_writes = 1'b1; w_rd_keep = 1'b1;
            w_illegal = ((w_f3 == 3'd1) && (w_f7 != 7'h00)) ||
                        ((w_f3 == 3'd5) && (w_f7 != 7'h00) && (w_f7 != 7'h20));
            w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
         end
         7'b0110011: begin
            w_class = C_OP;     w_writes = 1'b1; w_rd_keep = 1'b1;
            w_illegal = ((w_f7 != 7'h00) && (w_f7 != 7'h20)) ||
                        ((w_f7 == 7'h20) && (w_f3 != 3'd0) && (w_f3 != 3'd5));
         end
         7'b0001111: begin
            w_class = C_FENCE;  w_illegal = 1'b0;
         end
         7'b1110011: begin
            w_class = C_SYSTEM; w_illegal = 1'b0; w_writes = 1'b1; w_rd_keep = 1'b1;
            w_imm32 = {{20{w_ins[31]}}, w_ins[31:20]};
         end
         default: ;
      endcase
      if (w_ins[1:0] != 2'b11) w_illegal = 1'b1;
      if (w_illegal) begin
         w_class   = C_ILL;
         w_writes  = 1'b0;
         w_rd_keep = 1'b0;
         w_imm32   = 32'd0;
      end
   end

   assign w_rd        = w_rd_keep ? w_ins[11:7] : 5'd0;
   assign w_reg_write = w_writes && (w_rd != 5'd0);
   assign w_imm       = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

   assign decode_ready_o = enable_step_i && !flush_i &&
                           ((r_state == ST_EMPTY) || ((r_state == ST_FULL) && execute_ready_i));
   assign w_accept       = fetch_valid_i && decode_ready_o;
   assign decode_valid_o = (r_state != ST_EMPTY);
   assign illegal_o      = (r_state == ST_HALT);

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= ST_EMPTY;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (flush_i)
         w_state_next = ST_EMPTY;
      else if (w_accept)
         w_state_next = w_illegal ? ST_HALT : ST_FULL;
      else if ((r_state == ST_FULL) && execute_ready_i)
         w_state_next = ST_EMPTY;
   end

   // Payload only changes on accept, so backpressure and HALT hold it stable.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_o        <= RESET_PC;
         rs1_o       <= 5'd0;
         rs2_o       <= 5'd0;
         rd_o        <= 5'd0;
         imm_o       <= '0;
         funct3_o    <= 3'd0;
         funct7b5_o  <= 1'b0;
         op_class_o  <= 4'd0;
         reg_write_o <= 1'b0;
      end else if (w_accept) begin
         pc_o        <= pc_i;
         rs1_o       <= w_ins[19:15];
         rs2_o       <= w_ins[24:20];
         rd_o        <= w_rd;
         imm_o       <= w_imm;
         funct3_o    <= w_f3;
         funct7b5_o  <= w_ins[30];
         op_class_o  <= w_class;
         reg_write_o <= w_reg_write;
      end
   end

endmodule

// File: tb/tb_decode_step.sv
// Directed bench for decode_step: vector table for decode results plus
// hand-written sequences for backpressure, halt, flush, enable and reset.
module tb_decode_step;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic        fetch_valid = 1'b0;
   logic [31:0] instr = 32'd0;
   logic [31:0] pc = 32'd0;
   logic        ready;
   logic        flush = 1'b0;
   logic        exec_ready = 1'b1;
   logic        valid;
   logic [31:0] pc_out;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic [2:0]  f3;
   logic        f7b5;
   logic [3:0]  cls;
   logic        rw;
   logic        ill;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   decode_step dut (
      .clk_i(clk), .rst_i(rst), .enable_step_i(enable), .fetch_valid_i(fetch_valid),
      .instruction_i(instr), .pc_i(pc), .decode_ready_o(ready), .flush_i(flush),
      .execute_ready_i(exec_ready), .decode_valid_o(valid), .pc_o(pc_out),
      .rs1_o(rs1), .rs2_o(rs2), .rd_o(rd), .imm_o(imm), .funct3_o(f3),
      .funct7b5_o(f7b5), .op_class_o(cls), .reg_write_o(rw), .illegal_o(ill)
   );

   typedef struct {
      logic [31:0] ins;
      logic [3:0]  cls;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [2:0]  f3;
      logic        f7b5;
      logic        rw;
      logic        ill;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{32'h00500093, 4'd7,  5'd1, 5'd0,  5'd5,  32'h00000005, 3'd0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{32'h0020A423, 4'd6,  5'd0, 5'd1,  5'd2,  32'h00000008, 3'd2, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'hFE000EE3, 4'd4,  5'd0, 5'd0,  5'd0,  32'hFFFFFFFC, 3'd0, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{32'h123452B7, 4'd0,  5'd5, 5'd8,  5'd3,  32'h12345000, 3'd5, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{32'hFFFFFFFF, 4'd15, 5'd0, 5'd31, 5'd31, 32'h00000000, 3'd7, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{32'h008000EF, 4'd2,  5'd1, 5'd0,  5'd8,  32'h00000008, 3'd0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{32'h002081B3, 4'd8,  5'd3, 5'd1,  5'd2,  32'h00000000, 3'd0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{32'h402091B3, 4'd15, 5'd0, 5'd1,  5'd2,  32'h00000000, 3'd1, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{32'h00001067, 4'd15, 5'd0, 5'd0,  5'd0,  32'h00000000, 3'd1, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{32'h00100013, 4'd7,  5'd0, 5'd0,  5'd1,  32'h00000001, 3'd0, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{32'h0FF0000F, 4'd9,  5'd0, 5'd0,  5'd31, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{32'hFFC12283, 4'd5,  5'd5, 5'd2,  5'd28, 32'hFFFFFFFC, 3'd2, 1'b1, 1'b1, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_illegal", {31'd0, ill}, 32'd0);
      chk("rst_reg_write", {31'd0, rw}, 32'd0);
      chk("rst_pc", pc_out, 32'h80000000);
      chk("rst_class", {28'd0, cls}, 32'd0);
      chk("rst_imm", imm, 32'd0);
      chk("rst_rd", {27'd0, rd}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      $display("reset done");

      // Table-driven decode, back-to-back with execute always ready
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         fetch_valid = 1'b1;
         instr       = vecs[i].ins;
         pc          = 32'h80000000 + 32'(4 * i);
         exec_ready  = 1'b1;
         @(posedge clk);
         #1;
         fetch_valid = 1'b0;
         $display("vec %0d instr %h -> class %0d rd %0d rs1 %0d rs2 %0d imm %h rw %0d ill %0d",
                  i, vecs[i].ins, cls, rd, rs1, rs2, imm, rw, ill);
         chk($sformatf("v%0d_valid", i), {31'd0, valid}, 32'd1);
         chk($sformatf("v%0d_pc", i), pc_out, 32'h80000000 + 32'(4 * i));
         chk($sformatf("v%0d_class", i), {28'd0, cls}, {28'd0, vecs[i].cls});
         chk($sformatf("v%0d_rd", i), {27'd0, rd}, {27'd0, vecs[i].rd});
         chk($sformatf("v%0d_rs1", i), {27'd0, rs1}, {27'd0, vecs[i].rs1});
         chk($sformatf("v%0d_rs2", i), {27'd0, rs2}, {27'd0, vecs[i].rs2});
         chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
         chk($sformatf("v%0d_funct3", i), {29'd0, f3}, {29'd0, vecs[i].f3});
         chk($sformatf("v%0d_f7b5", i), {31'd0, f7b5}, {31'd0, vecs[i].f7b5});
         chk($sformatf("v%0d_reg_write", i), {31'd0, rw}, {31'd0, vecs[i].rw});
         chk($sformatf("v%0d_illegal", i), {31'd0, ill}, {31'd0, vecs[i].ill});
         chk($sformatf("v%0d_ready", i), {31'd0, ready}, {31'd0, !vecs[i].ill});
         if (vecs[i].ill) begin
            @(negedge clk);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
         end
      end

      // Return to EMPTY
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;

      // Backpressure: FULL held three cycles with fetch waiting
      exec_ready  = 1'b0;
      fetch_valid = 1'b1;
      instr       = 32'h00500093;
      pc          = 32'h80000100;
      @(posedge clk);
      #1;
      instr = 32'h123452B7;
      pc    = 32'h80000104;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("bp%0d_ready", k), {31'd0, ready}, 32'd0);
         @(posedge clk);
         #1;
         $display("backpressure cycle %0d valid %0d rd %0d imm %h", k, valid, rd, imm);
         chk($sformatf("bp%0d_valid", k), {31'd0, valid}, 32'd1);
         chk($sformatf("bp%0d_rd", k), {27'd0, rd}, 32'd1);
         chk($sformatf("bp%0d_imm", k), imm, 32'd5);
         chk($sformatf("bp%0d_pc", k), pc_out, 32'h80000100);
      end
      @(negedge clk);
      exec_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, ready}, 32'd1);
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
      $display("backpressure release class %0d rd %0d pc %h", cls, rd, pc_out);
      chk("bp_new_class", {28'd0, cls}, 32'd0);
      chk("bp_new_rd", {27'd0, rd}, 32'd5);
      chk("bp_new_pc", pc_out, 32'h80000104);

      // Disabled stage: no accept, but output can still be consumed
      @(negedge clk);
      enable      = 1'b0;
      exec_ready  = 1'b0;
      fetch_valid = 1'b1;
      instr       = 32'h00500093;
      #1;
      chk("en0_ready", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("en0_hold_valid", {31'd0, valid}, 32'd1);
      chk("en0_hold_rd", {27'd0, rd}, 32'd5);
      @(negedge clk);
      exec_ready = 1'b1;
      #1;
      chk("en0_ready_consume", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
      $display("disabled consume valid %0d", valid);
      chk("en0_consumed_valid", {31'd0, valid}, 32'd0);
      @(negedge clk);
      enable      = 1'b1;
      fetch_valid = 1'b0;

      // Illegal word halts despite execute ready and pending fetch
      @(negedge clk);
      fetch_valid = 1'b1;
      instr       = 32'hFFFFFFFF;
      pc          = 32'h80000180;
      @(posedge clk);
      #1;
      instr = 32'h00500093;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("halt%0d_ready", k), {31'd0, ready}, 32'd0);
         @(posedge clk);
         #1;
         $display("halt cycle %0d valid %0d illegal %0d class %0d", k, valid, ill, cls);
         chk($sformatf("halt%0d_illegal", k), {31'd0, ill}, 32'd1);
         chk($sformatf("halt%0d_valid", k), {31'd0, valid}, 32'd1);
         chk($sformatf("halt%0d_class", k), {28'd0, cls}, 32'd15);
         chk($sformatf("halt%0d_rw", k), {31'd0, rw}, 32'd0);
      end
      @(negedge clk);
      flush       = 1'b1;
      fetch_valid = 1'b0;
      @(posedge clk);
      #1;
      $display("flush from halt valid %0d illegal %0d", valid, ill);
      chk("halt_flush_valid", {31'd0, valid}, 32'd0);
      chk("halt_flush_illegal", {31'd0, ill}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      chk("halt_flush_ready", {31'd0, ready}, 32'd1);

      // Flush and fetch in the same cycle: nothing captured
      @(negedge clk);
      flush       = 1'b1;
      fetch_valid = 1'b1;
      instr       = 32'h00500093;
      #1;
      chk("flush_acc_ready", {31'd0, ready}, 32'd0);
      @(posedge clk);
      #1;
      chk("flush_acc_valid", {31'd0, valid}, 32'd0);
      @(negedge clk);
      flush       = 1'b0;
      fetch_valid = 1'b0;
      @(posedge clk);
      #1;
      $display("flush with fetch valid %0d", valid);
      chk("flush_acc_valid2", {31'd0, valid}, 32'd0);

      // Reset while FULL
      @(negedge clk);
      fetch_valid = 1'b1;
      instr       = 32'h123452B7;
      pc          = 32'h80000200;
      exec_ready  = 1'b0;
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
      chk("rf_valid_before", {31'd0, valid}, 32'd1);
      chk("rf_pc_before", pc_out, 32'h80000200);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      $display("reset in full valid %0d pc %h", valid, pc_out);
      chk("rf_valid", {31'd0, valid}, 32'd0);
      chk("rf_pc", pc_out, 32'h80000000);
      chk("rf_rd", {27'd0, rd}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
